// File: rtl/frg1_bist_pkg.sv
// Shared constants, state encoding and LFSR step for the frg1 BIST driver.
package frg1_bist_pkg;

    localparam int N_IN  = 28;
    localparam int N_OUT = 3;
    localparam int SIG_W = 16;

    // Maximal-length feedback x^28 + x^25 + 1, expressed as register tap indices
    localparam int LFSR_TAP_HI = 27;
    localparam int LFSR_TAP_LO = 24;

    // Substitute load value when the configured seed is the lock-up state
    localparam logic [N_IN-1:0] LFSR_ONE = 28'h0000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_APPLY,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // One Fibonacci shift of the stimulus LFSR
    function automatic logic [N_IN-1:0] lfsr_next(input logic [N_IN-1:0] v);
        return {v[N_IN-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/frg1_bist_misr.sv
// Multiple-input signature register compacting DUT responses into SIG_W bits.
module bist_misr
    import frg1_bist_pkg::*;
#(
    parameter int               SIG_W_P = SIG_W,
    parameter logic [SIG_W_P-1:0] POLY  = 16'h1021,
    parameter int               DATA_W  = N_OUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [DATA_W-1:0]  data,
    output logic [SIG_W_P-1:0] sig,
    output logic [SIG_W_P-1:0] sig_next
);

    // Next signature: shift, fold the feedback polynomial, inject the response
    // NOTE: every path assigns sig_next, so this stays combinational with no latch.
    always_comb begin
        sig_next = {sig[SIG_W_P-2:0], 1'b0} ^ (sig[SIG_W_P-1] ? POLY : '0)
                 ^ SIG_W_P'(data);
    end

    // Signature register: cleared at run start, updated once per captured pattern
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/frg1_bist_driver.sv
// frg1 BIST driver: LFSR stimulus into the function under test, MISR response
// compaction, golden-signature compare and a start/done/abort handshake.
module frg1_bist_driver
    import frg1_bist_pkg::*;
#(
    parameter int               PATTERNS  = 1024,
    parameter logic [N_IN-1:0]  SEED      = 28'h0000001,
    parameter int               CAP_LAT   = 0,
    parameter logic [SIG_W-1:0] MISR_POLY = 16'h1021,
    localparam int              CNT_W     = $clog2(PATTERNS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SIG_W-1:0]  golden,
    input  logic [N_OUT-1:0]  f,
    output logic [N_IN-1:0]   x,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  pat_cnt
);

    localparam logic [N_IN-1:0]   LOAD_VAL  = (SEED == '0) ? LFSR_ONE : SEED;
    localparam logic [CNT_W-1:0]  PAT_MAX   = CNT_W'(PATTERNS);
    localparam int                WAIT_W    = (CAP_LAT > 1) ? $clog2(CAP_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (CAP_LAT > 0) ? WAIT_W'(CAP_LAT - 1) : '0;

    state_t            state;
    logic [SIG_W-1:0]  golden_q;
    logic [SIG_W-1:0]  sig_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              last_pat;
    logic              misr_clear;
    logic              misr_en;

    // The capture in progress is the final one of the run
    assign last_pat   = (pat_cnt >= PAT_MAX - CNT_W'(1));
    // An abort in the same cycle suppresses any signature update
    assign misr_clear = (state == ST_LOAD) && !abort;
    assign misr_en    = (state == ST_CAPTURE) && !abort;

    bist_misr #(
        .SIG_W_P (SIG_W),
        .POLY    (MISR_POLY),
        .DATA_W  (N_OUT)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (misr_clear),
        .enable   (misr_en),
        .data     (f),
        .sig      (signature),
        .sig_next (sig_next)
    );

    // Run sequencer: stimulus register, pattern count and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            x        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            pat_cnt  <= '0;
            golden_q <= '0;
            wait_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (busy && abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            state    <= ST_LOAD;
                            busy     <= 1'b1;
                            pass     <= 1'b0;
                            golden_q <= golden;
                        end
                    end
                    ST_LOAD: begin
                        x       <= LOAD_VAL;
                        pat_cnt <= '0;
                        state   <= ST_APPLY;
                    end
                    ST_APPLY: begin
                        wait_cnt <= '0;
                        state    <= (CAP_LAT == 0) ? ST_CAPTURE : ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            state <= ST_CAPTURE;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    ST_CAPTURE: begin
                        x       <= lfsr_next(x);
                        pat_cnt <= (pat_cnt == PAT_MAX) ? pat_cnt : pat_cnt + CNT_W'(1);
                        if (last_pat) begin
                            // Compare the signature as it stands after this capture
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (sig_next == golden_q);
                        end else begin
                            state <= ST_APPLY;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frg1_bist_driver.sv
// Self-checking bench for frg1_bist_driver: two instances (combinational DUT path
// and a 2-stage delayed DUT path) driven by randomized response functions.
module tb_frg1_bist_driver;

    localparam int          PAT_A  = 4;
    localparam int          PAT_B  = 8;
    localparam logic [27:0] SEED_A = 28'h0000001;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_a, abort_a, busy_a, done_a, pass_a;
    logic [15:0] golden_a, sig_a;
    logic [2:0]  f_a, cnt_a;
    logic [27:0] x_a;

    logic        start_b, abort_b, busy_b, done_b, pass_b;
    logic [15:0] golden_b, sig_b;
    logic [2:0]  f_b;
    logic [3:0]  cnt_b;
    logic [27:0] x_b;

    // Response function of the stand-in DUT: parity of masked input bits per output
    logic [27:0] m0, m1, m2, flip_x;
    logic [2:0]  f_const;
    logic        flip_on;
    logic [2:0]  d1 = '0, d2 = '0;

    logic [27:0] exp_x [0:16];
    int          n_checks = 0;
    int          n_fail   = 0;

    frg1_bist_driver #(.PATTERNS(PAT_A), .SEED(SEED_A), .CAP_LAT(0), .MISR_POLY(16'h1021)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .golden(golden_a), .f(f_a),
        .x(x_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pat_cnt(cnt_a)
    );

    frg1_bist_driver #(.PATTERNS(PAT_B), .SEED(28'h0), .CAP_LAT(2), .MISR_POLY(16'h1021)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .golden(golden_b), .f(f_b),
        .x(x_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pat_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    assign f_a = {^(x_a & m2), ^(x_a & m1), ^(x_a & m0)} ^ f_const
               ^ {2'b00, flip_on && (x_a == flip_x)};

    // Two-stage registered stand-in DUT for the CAP_LAT=2 instance
    always @(posedge clk) begin
        d1 <= {^(x_b & m2), ^(x_b & m1), ^(x_b & m0)} ^ f_const;
        d2 <= d1;
    end
    assign f_b = d2;

    // ---------------- reference model ----------------
    function automatic logic [27:0] model_lfsr(input logic [27:0] v);
        logic [27:0] fb;
        fb = ((v >> 27) ^ (v >> 24)) & 28'd1;
        return (v << 1) | fb;
    endfunction

    function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [2:0] r);
        logic [16:0] t;
        t = {1'b0, s} << 1;
        if (t[16]) t = t ^ 17'h01021;
        return t[15:0] ^ {13'd0, r};
    endfunction

    function automatic logic [2:0] model_resp(input logic [27:0] v);
        return {^(v & m2), ^(v & m1), ^(v & m0)} ^ f_const ^ {2'b00, flip_on && (v == flip_x)};
    endfunction

    // Expected x per pattern (exp_x[0..p]) and final signature after p captures
    task automatic model_run(input logic [27:0] seed, input int p, output logic [15:0] sig);
        logic [27:0] v;
        v   = (seed == 28'd0) ? 28'd1 : seed;
        sig = 16'h0000;
        for (int j = 0; j < p; j++) begin
            exp_x[j] = v;
            sig      = model_misr(sig, model_resp(v));
            v        = model_lfsr(v);
        end
        exp_x[p] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_resp();
        m0      = 28'($urandom);
        m1      = 28'($urandom);
        m2      = 28'($urandom);
        f_const = 3'($urandom);
    endtask

    // Full run on instance A: x per pattern, done latency, signature, pass, count
    task automatic run_a(input string name, input logic [15:0] gold, input logic [15:0] exp_sig,
                         input int restart_at);
        int   t;
        logic exp_pass;
        exp_pass = (exp_sig == gold);
        golden_a = gold; start_a = 1'b1;
        tick();
        start_a  = 1'b0; golden_a = ~gold; t = 1;
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start: got %b want 1", name, busy_a); end
        while (done_a !== 1'b1 && t < 200) begin
            start_a = (t == restart_at);
            tick(); t++;
            if (t >= 2 && (t - 2) % 2 == 0 && (t - 2) / 2 < PAT_A) begin
                n_checks++;
                if (x_a !== exp_x[(t - 2) / 2]) begin
                    n_fail++; $display("FAIL %s x[%0d]: got %h want %h", name, (t - 2) / 2, x_a, exp_x[(t - 2) / 2]);
                end
            end
        end
        start_a = 1'b0;
        n_checks++; if (t != 2 + 2 * PAT_A) begin n_fail++; $display("FAIL %s done_latency: got %0d want %0d", name, t, 2 + 2 * PAT_A); end
        n_checks++; if (sig_a !== exp_sig) begin n_fail++; $display("FAIL %s signature: got %h want %h", name, sig_a, exp_sig); end
        n_checks++; if (pass_a !== exp_pass) begin n_fail++; $display("FAIL %s pass: got %b want %b", name, pass_a, exp_pass); end
        n_checks++; if (cnt_a !== 3'(PAT_A)) begin n_fail++; $display("FAIL %s pat_cnt: got %0d want %0d", name, cnt_a, PAT_A); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: got %b want 0", name, busy_a); end
        tick();
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL %s done_width: got %b want 0", name, done_a); end
        n_checks++; if (pass_a !== exp_pass || sig_a !== exp_sig) begin
            n_fail++; $display("FAIL %s hold: got pass=%b sig=%h want pass=%b sig=%h", name, pass_a, sig_a, exp_pass, exp_sig);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++;
        if (x_a !== 28'd0 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || sig_a !== 16'd0 || cnt_a !== 3'd0) begin
            n_fail++; $display("FAIL reset_a: got x=%h busy=%b done=%b pass=%b sig=%h cnt=%0d want all zero",
                               x_a, busy_a, done_a, pass_a, sig_a, cnt_a);
        end
        n_checks++;
        if (x_b !== 28'd0 || busy_b !== 1'b0 || done_b !== 1'b0 || pass_b !== 1'b0 || sig_b !== 16'd0 || cnt_b !== 4'd0) begin
            n_fail++; $display("FAIL reset_b: got x=%h busy=%b done=%b pass=%b sig=%h cnt=%0d want all zero",
                               x_b, busy_b, done_b, pass_b, sig_b, cnt_b);
        end
    endtask

    task automatic test_const_resp();
        logic [15:0] s;
        m0 = '0; m1 = '0; m2 = '0; flip_on = 1'b0;
        f_const = 3'b000;
        model_run(SEED_A, PAT_A, s);
        run_a("const0", 16'h0000, 16'h0000, -1);
        f_const = 3'b001;
        model_run(SEED_A, PAT_A, s);
        run_a("const1_pass", 16'h000F, 16'h000F, -1);
        run_a("const1_fail", 16'h000E, 16'h000F, -1);
    endtask

    task automatic test_random();
        logic [15:0] s, gold;
        flip_on = 1'b0;
        for (int k = 0; k < 4; k++) begin
            randomize_resp();
            model_run(SEED_A, PAT_A, s);
            gold = (k % 2 == 0) ? s : s ^ 16'(($urandom % 16'hFFFF) + 1);
            run_a("random", gold, s, -1);
        end
    endtask

    task automatic test_fault_flip();
        logic [15:0] clean, faulty;
        randomize_resp();
        flip_on = 1'b0;
        model_run(SEED_A, PAT_A, clean);
        flip_x  = exp_x[$urandom_range(0, PAT_A - 1)];
        flip_on = 1'b1;
        model_run(SEED_A, PAT_A, faulty);
        run_a("flip_f0", clean, faulty, -1);
        flip_on = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        randomize_resp();
        model_run(SEED_A, PAT_A, s);
        run_a("start_while_busy", s, s, 4);
    endtask

    task automatic test_abort();
        logic [15:0] s3, s_full;
        logic        saw;
        randomize_resp();
        model_run(SEED_A, PAT_A, s_full);
        run_a("pre_abort", s_full, s_full, -1);
        model_run(SEED_A, 3, s3);
        golden_a = s_full; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
        n_checks++; if (cnt_a !== 3'd3) begin n_fail++; $display("FAIL abort_cnt: got %0d want 3", cnt_a); end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        n_checks++;
        if (busy_a !== 1'b0 || pass_a !== 1'b0 || done_a !== 1'b0 || sig_a !== s3 || x_a !== exp_x[3]) begin
            n_fail++; $display("FAIL abort_state: got busy=%b pass=%b done=%b sig=%h x=%h want 0 0 0 %h %h",
                               busy_a, pass_a, done_a, sig_a, x_a, s3, exp_x[3]);
        end
        saw = 1'b0;
        repeat (12) begin tick(); if (done_a === 1'b1 || busy_a === 1'b1) saw = 1'b1; end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got activity=%b want 0", saw); end
        start_a = 1'b1; abort_a = 1'b1;
        tick();
        start_a = 1'b0; abort_a = 1'b0;
        tick();
        n_checks++; if (busy_a !== 1'b0 || x_a !== exp_x[3]) begin
            n_fail++; $display("FAIL start_abort_idle: got busy=%b x=%h want 0 %h", busy_a, x_a, exp_x[3]);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] s;
        logic        saw;
        randomize_resp();
        model_run(SEED_A, PAT_A, s);
        run_a("pre_reset", s, s, -1);
        golden_a = s; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (x_a !== 28'd0 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || sig_a !== 16'd0 || cnt_a !== 3'd0) begin
            n_fail++; $display("FAIL async_reset: got x=%h busy=%b done=%b pass=%b sig=%h cnt=%0d want all zero",
                               x_a, busy_a, done_a, pass_a, sig_a, cnt_a);
        end
        #1 rst_n = 1'b1;
        saw = 1'b0;
        repeat (12) begin tick(); if (done_a === 1'b1 || busy_a === 1'b1) saw = 1'b1; end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL reset_no_done: got activity=%b want 0", saw); end
    endtask

    task automatic test_cap_lat();
        logic [15:0] s, gold;
        int          t;
        randomize_resp();
        flip_on = 1'b0;
        model_run(28'h0, PAT_B, s);
        for (int k = 0; k < 2; k++) begin
            gold = (k == 0) ? s : s ^ 16'h8001;
            golden_b = gold; start_b = 1'b1;
            tick();
            start_b = 1'b0; t = 1;
            while (done_b !== 1'b1 && t < 400) begin
                tick(); t++;
                if (t >= 2 && (t - 2) % 4 == 0 && (t - 2) / 4 < PAT_B) begin
                    n_checks++;
                    if (x_b !== exp_x[(t - 2) / 4]) begin
                        n_fail++; $display("FAIL caplat x[%0d]: got %h want %h", (t - 2) / 4, x_b, exp_x[(t - 2) / 4]);
                    end
                end
            end
            n_checks++; if (t != 2 + 4 * PAT_B) begin n_fail++; $display("FAIL caplat_latency: got %0d want %0d", t, 2 + 4 * PAT_B); end
            n_checks++; if (sig_b !== s) begin n_fail++; $display("FAIL caplat_signature: got %h want %h", sig_b, s); end
            n_checks++; if (pass_b !== (k == 0)) begin n_fail++; $display("FAIL caplat_pass: got %b want %b", pass_b, (k == 0)); end
            n_checks++; if (cnt_b !== 4'(PAT_B)) begin n_fail++; $display("FAIL caplat_cnt: got %0d want %0d", cnt_b, PAT_B); end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; golden_a = '0;
        start_b = 1'b0; abort_b = 1'b0; golden_b = '0;
        m0 = '0; m1 = '0; m2 = '0; f_const = '0; flip_on = 1'b0; flip_x = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_const_resp();
        test_random();
        test_fault_flip();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_cap_lat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
